// File: rtl/simple_core.sv
// Five-phase multi-cycle SIMPLE core: fetch, decode, execute, memory, writeback.
// Each instruction takes exactly five clocks; exec starts the core from idle or pauses it.
module simple_core #(
  parameter int              DATA_W   = 16,
  parameter int              ADDR_W   = 12,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              exec,
  input  logic [DATA_W-1:0] m_q,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_data,
  output logic              m_we,
  output logic [4:0]        phase,
  output logic              running,
  output logic              halted
);
  typedef enum logic [2:0] {IDLE, P1, P2, P3, P4, P5} state_t;

  state_t                 state;
  logic [ADDR_W-1:0]      pc;
  logic [7:0][DATA_W-1:0] rf;
  logic [3:0]             szcv;
  logic [15:0]            ir;
  logic [DATA_W-1:0]      ar, br, dr, d;
  logic                   pause_pend;

  logic [1:0] op1;
  logic [2:0] op2;
  logic [3:0] op3, sh;
  logic       is_ld, is_st, is_li, is_hlt, alu_wr;
  logic signed [7:0] q_off, ir_off;

  assign op1    = ir[15:14];
  assign op2    = ir[13:11];
  assign op3    = ir[7:4];
  assign sh     = ir[3:0];
  assign q_off  = m_q[7:0];
  assign ir_off = ir[7:0];
  assign is_ld  = (op1 == 2'b00);
  assign is_st  = (op1 == 2'b01);
  assign is_li  = (op1 == 2'b10) && (op2 == 3'b000);
  assign is_hlt = (op1 == 2'b11) && (op3 == 4'hF);
  assign alu_wr = (op1 == 2'b11) &&
                  (op3 inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd8, 4'd9, 4'd10, 4'd11});

  // Carry/borrow come from the extra top bit; shifts carry the last bit out in the spare bit.
  logic [DATA_W:0]   sum, diff, sll_w, srl_w, sra_w;
  logic [DATA_W-1:0] rol;
  assign sum   = {1'b0, br} + {1'b0, ar};
  assign diff  = {1'b0, br} - {1'b0, ar};
  assign sll_w = {1'b0, br} << sh;
  assign srl_w = {br, 1'b0} >> sh;
  assign sra_w = $signed({br, 1'b0}) >>> sh;
  assign rol   = (br << sh) | (br >> (DATA_W - int'(sh)));

  logic [DATA_W-1:0] res;
  logic              c, v, upd, take;
  logic              fs, fz, fv;
  assign fs = szcv[3];
  assign fz = szcv[2];
  assign fv = szcv[0];

  always_comb begin
    res  = '0;
    c    = 1'b0;
    v    = 1'b0;
    upd  = 1'b0;
    take = 1'b0;
    case (op1)
      2'b00, 2'b01: res = br + d;
      2'b10: begin
        if (op2 == 3'b100) take = 1'b1;
        else if (op2 == 3'b111) begin
          case (ir[10:8])
            3'd0:    take = fz;
            3'd1:    take = fs ^ fv;
            3'd2:    take = fz | (fs ^ fv);
            3'd3:    take = !fz;
            default: take = 1'b0;
          endcase
        end
      end
      default: begin
        upd = 1'b1;
        case (op3)
          4'd0: begin
            {c, res} = sum;
            v = (br[DATA_W-1] == ar[DATA_W-1]) && (sum[DATA_W-1] != br[DATA_W-1]);
          end
          4'd1, 4'd5: begin
            {c, res} = diff;
            v = (br[DATA_W-1] != ar[DATA_W-1]) && (diff[DATA_W-1] != br[DATA_W-1]);
          end
          4'd2:  res = br & ar;
          4'd3:  res = br | ar;
          4'd4:  res = br ^ ar;
          4'd6:  res = ar;
          4'd8:  {c, res} = sll_w;
          4'd9:  begin res = rol; c = (sh != 4'd0) && rol[0]; end
          4'd10: {res, c} = srl_w;
          4'd11: {res, c} = sra_w;
          default: upd = 1'b0;
        endcase
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      phase      <= '0;
      running    <= 1'b0;
      halted     <= 1'b0;
      pause_pend <= 1'b0;
      pc         <= RESET_PC;
      rf         <= '0;
      szcv       <= '0;
      ir         <= '0;
      ar         <= '0;
      br         <= '0;
      dr         <= '0;
      d          <= '0;
      m_addr     <= '0;
      m_data     <= '0;
      m_we       <= 1'b0;
    end else begin
      // A P5 exec is handled by the stop decision below, not by the pending flag.
      if (exec && running && state != P5) pause_pend <= 1'b1;
      case (state)
        IDLE: if (exec) begin
          state   <= P1;
          phase   <= 5'b00001;
          running <= 1'b1;
          halted  <= 1'b0;
          m_addr  <= pc;
        end
        P1: begin
          pc    <= pc + ADDR_W'(1);
          state <= P2;
          phase <= 5'b00010;
        end
        P2: begin
          ir    <= m_q[15:0];
          ar    <= rf[m_q[13:11]];
          br    <= rf[m_q[10:8]];
          d     <= DATA_W'(q_off);
          state <= P3;
          phase <= 5'b00100;
        end
        P3: begin
          dr <= res;
          if (upd) szcv <= {res[DATA_W-1], res == '0, c, v};
          if (take) pc <= pc + ADDR_W'(ir_off);
          if (is_ld || is_st) m_addr <= res[ADDR_W-1:0];
          if (is_st) begin
            m_data <= ar;
            m_we   <= 1'b1;
          end
          state <= P4;
          phase <= 5'b01000;
        end
        P4: begin
          m_we  <= 1'b0;
          state <= P5;
          phase <= 5'b10000;
        end
        P5: begin
          if (is_ld) rf[ir[13:11]] <= m_q;
          else if (is_li) rf[ir[10:8]] <= d;
          else if (alu_wr) rf[ir[10:8]] <= dr;
          if (is_hlt || pause_pend || exec) begin
            state      <= IDLE;
            phase      <= '0;
            running    <= 1'b0;
            pause_pend <= 1'b0;
            halted     <= is_hlt;
          end else begin
            state  <= P1;
            phase  <= 5'b00001;
            m_addr <= pc;
          end
        end
        default: begin
          state <= IDLE;
          phase <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_simple_core.sv
// Bench for simple_core: directed programs plus random programs against an ISA-level model.
module tb_simple_core;
  localparam int DW = 16;
  localparam int AW = 12;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          exec  = 1'b0;
  logic [DW-1:0] m_q;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic          m_we;
  logic [4:0]    phase;
  logic          running, halted;

  simple_core #(.DATA_W(DW), .ADDR_W(AW), .RESET_PC('0)) dut (
    .clock(clock), .reset(reset), .exec(exec), .m_q(m_q), .m_addr(m_addr),
    .m_data(m_data), .m_we(m_we), .phase(phase), .running(running), .halted(halted)
  );

  always #5 clock = ~clock;

  logic [15:0] mem     [0:4095];
  logic [15:0] ref_mem [0:4095];
  logic [15:0] exp_r   [0:7];
  logic [3:0]  exp_f;
  int          exp_pc;
  int          vectors = 0;
  int          miscompares = 0;

  // Synchronous single-port memory, read-before-write.
  always @(posedge clock) begin
    m_q <= mem[m_addr];
    if (m_we) mem[m_addr] = m_data;
  end

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) begin mem[i] = '0; ref_mem[i] = '0; end
  endtask

  task automatic put(input int a, input logic [15:0] val);
    mem[a] = val; ref_mem[a] = val;
  endtask

  task automatic do_reset();
    @(negedge clock); reset = 1'b1; exec = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic start();
    @(negedge clock); exec = 1'b1;
    @(negedge clock); exec = 1'b0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (running && cyc < 5000) begin @(negedge clock); cyc++; end
    vectors++;
    if (running !== 1'b0) begin miscompares++; $display("FAIL wait_idle: got running=%b want 0 after %0d cycles", running, cyc); end
  endtask

  // Instruction-set-level reference: executes ref_mem from address 0 until HLT.
  task automatic model_run(output int n);
    int pc, x, y, xs, ys, res, sv, sh, d, addr;
    bit c, v, halt, take, wr, upd;
    logic [15:0] ir;
    for (int i = 0; i < 8; i++) exp_r[i] = '0;
    exp_f = '0; pc = 0; n = 0; halt = 0;
    while (!halt && n < 500) begin
      ir = ref_mem[pc]; pc = (pc + 1) % 4096; n++;
      d  = int'($signed(ir[7:0]));
      x  = int'(exp_r[ir[10:8]]);
      y  = int'(exp_r[ir[13:11]]);
      xs = (x >= 32768) ? x - 65536 : x;
      ys = (y >= 32768) ? y - 65536 : y;
      addr = (x + d) & 'hFFF;
      case (ir[15:14])
        2'd0: exp_r[ir[13:11]] = ref_mem[addr];
        2'd1: ref_mem[addr] = exp_r[ir[13:11]];
        2'd2: begin
          take = 0;
          if (ir[13:11] == 3'd0) exp_r[ir[10:8]] = 16'(d);
          else if (ir[13:11] == 3'd4) take = 1;
          else if (ir[13:11] == 3'd7)
            case (ir[10:8])
              3'd0: take = exp_f[2];
              3'd1: take = exp_f[3] ^ exp_f[0];
              3'd2: take = exp_f[2] | (exp_f[3] ^ exp_f[0]);
              3'd3: take = !exp_f[2];
              default: take = 0;
            endcase
          if (take) pc = (pc + d) & 'hFFF;
        end
        default: begin
          sh = int'(ir[3:0]); c = 0; v = 0; upd = 1; wr = 1; res = 0;
          case (ir[7:4])
            4'd0: begin res = x + y; c = res > 65535; sv = xs + ys; v = sv > 32767 || sv < -32768; end
            4'd1, 4'd5: begin res = x - y; c = x < y; sv = xs - ys; v = sv > 32767 || sv < -32768; wr = (ir[7:4] == 4'd1); end
            4'd2: res = x & y;
            4'd3: res = x | y;
            4'd4: res = x ^ y;
            4'd6: res = y;
            4'd8: begin res = x << sh; c = sh != 0 && ((x >> (16 - sh)) & 1) != 0; end
            4'd9: begin res = ((x << sh) | (x >> (16 - sh))) & 'hFFFF; c = sh != 0 && (res & 1) != 0; end
            4'd10: begin res = x >> sh; c = sh != 0 && ((x >> (sh - 1)) & 1) != 0; end
            4'd11: begin res = xs >>> sh; c = sh != 0 && ((x >> (sh - 1)) & 1) != 0; end
            4'd15: begin halt = 1; upd = 0; wr = 0; end
            default: begin upd = 0; wr = 0; end
          endcase
          res = res & 'hFFFF;
          if (upd) exp_f = {res[15], res == 0, c, v};
          if (wr) exp_r[ir[10:8]] = 16'(res);
        end
      endcase
    end
    exp_pc = pc;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    vectors++; if (phase !== 5'b0) begin miscompares++; $display("FAIL reset_phase: got %b want 00000", phase); end
    vectors++; if (running !== 1'b0 || halted !== 1'b0) begin miscompares++; $display("FAIL reset_status: got run=%b halt=%b want 0 0", running, halted); end
    vectors++; if (m_we !== 1'b0 || m_addr !== '0 || m_data !== '0) begin miscompares++; $display("FAIL reset_mem_if: got we=%b addr=%h data=%h want 0 0 0", m_we, m_addr, m_data); end
    vectors++; if (dut.pc !== '0 || dut.szcv !== 4'b0) begin miscompares++; $display("FAIL reset_pc_flags: got pc=%h szcv=%b want 0 0", dut.pc, dut.szcv); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int cyc;
    clear_mem();
    put(0, 16'h8105); put(1, 16'h82FD); put(2, 16'hD100); put(3, 16'hC0F0);
    do_reset(); start(); wait_idle(cyc);
    vectors++; if (cyc != 20) begin miscompares++; $display("FAIL basic_cycles: got %0d want 20", cyc); end
    vectors++; if (dut.rf[1] !== 16'h0002) begin miscompares++; $display("FAIL basic_r1: got %h want 0002", dut.rf[1]); end
    vectors++; if (dut.rf[2] !== 16'hFFFD) begin miscompares++; $display("FAIL basic_r2: got %h want fffd", dut.rf[2]); end
    vectors++; if (dut.szcv !== 4'b0010) begin miscompares++; $display("FAIL basic_szcv: got %b want 0010", dut.szcv); end
    vectors++; if (halted !== 1'b1 || phase !== 5'b0) begin miscompares++; $display("FAIL basic_halt: got halted=%b phase=%b want 1 00000", halted, phase); end
  endtask

  task automatic test_ld_st();
    int cyc, we_cnt;
    logic [4:0] we_ph; logic [AW-1:0] we_a; logic [DW-1:0] we_d;
    clear_mem();
    put(0, 16'h0840); put(1, 16'h4804); put(2, 16'h1804); put(3, 16'hC0F0); put(16'h40, 16'h1234);
    do_reset(); start();
    cyc = 0; we_cnt = 0; we_ph = '0; we_a = '0; we_d = '0;
    while (running && cyc < 200) begin
      if (m_we) begin we_cnt++; we_ph = phase; we_a = m_addr; we_d = m_data; end
      @(negedge clock); cyc++;
    end
    vectors++; if (cyc != 20) begin miscompares++; $display("FAIL ldst_cycles: got %0d want 20", cyc); end
    vectors++; if (we_cnt != 1 || we_ph !== 5'b01000) begin miscompares++; $display("FAIL ldst_we: got count=%0d phase=%b want 1 01000", we_cnt, we_ph); end
    vectors++; if (we_a !== 12'h004 || we_d !== 16'h1234) begin miscompares++; $display("FAIL ldst_bus: got addr=%h data=%h want 004 1234", we_a, we_d); end
    vectors++; if (mem[4] !== 16'h1234) begin miscompares++; $display("FAIL ldst_mem: got %h want 1234", mem[4]); end
    vectors++; if (dut.rf[3] !== 16'h1234) begin miscompares++; $display("FAIL ldst_r3: got %h want 1234", dut.rf[3]); end
  endtask

  task automatic test_branch();
    int cyc;
    clear_mem();
    put(0, 16'h8107); put(1, 16'hC950); put(2, 16'hB802); put(3, 16'h8201);
    put(4, 16'h8202); put(5, 16'hBB01); put(6, 16'h8303); put(7, 16'hC0F0);
    do_reset(); start(); wait_idle(cyc);
    vectors++; if (cyc != 30) begin miscompares++; $display("FAIL br_cycles: got %0d want 30", cyc); end
    vectors++; if (dut.rf[2] !== 16'h0) begin miscompares++; $display("FAIL br_be_skip: got r2=%h want 0000", dut.rf[2]); end
    vectors++; if (dut.rf[3] !== 16'h3) begin miscompares++; $display("FAIL br_bne_fall: got r3=%h want 0003", dut.rf[3]); end
    vectors++; if (dut.szcv !== 4'b0100 || dut.pc !== 12'h008) begin miscompares++; $display("FAIL br_state: got szcv=%b pc=%h want 0100 008", dut.szcv, dut.pc); end
  endtask

  task automatic test_shift();
    int cyc;
    clear_mem();
    put(0, 16'h0840); put(1, 16'hC1B4); put(2, 16'hC0F0); put(16'h40, 16'h8010);
    do_reset(); start(); wait_idle(cyc);
    vectors++; if (dut.rf[1] !== 16'hF801 || dut.szcv !== 4'b1000) begin miscompares++; $display("FAIL sra: got r1=%h szcv=%b want f801 1000", dut.rf[1], dut.szcv); end
    clear_mem();
    put(0, 16'h1041); put(1, 16'hC291); put(2, 16'hC0F0); put(16'h41, 16'h8000);
    do_reset(); start(); wait_idle(cyc);
    vectors++; if (dut.rf[2] !== 16'h0001 || dut.szcv !== 4'b0010) begin miscompares++; $display("FAIL slr: got r2=%h szcv=%b want 0001 0010", dut.rf[2], dut.szcv); end
  endtask

  task automatic test_pause();
    int cyc, cnt;
    clear_mem();
    put(0, 16'h8101); put(1, 16'h8202); put(2, 16'hD100); put(3, 16'h8409); put(4, 16'hC0F0);
    do_reset(); start();
    cnt = 0; cyc = 0;
    while (cnt < 3 && cyc < 200) begin
      if (phase == 5'b00100) cnt++;
      if (cnt < 3) begin @(negedge clock); cyc++; end
    end
    vectors++; if (cnt != 3) begin miscompares++; $display("FAIL pause_find_p3: got %0d want 3", cnt); end
    exec = 1'b1; @(negedge clock); exec = 1'b0;
    wait_idle(cyc);
    vectors++; if (halted !== 1'b0 || dut.rf[1] !== 16'h3 || dut.rf[4] !== 16'h0) begin miscompares++; $display("FAIL pause_stop: got halted=%b r1=%h r4=%h want 0 0003 0000", halted, dut.rf[1], dut.rf[4]); end
    vectors++; if (dut.pc !== 12'h003) begin miscompares++; $display("FAIL pause_pc: got %h want 003", dut.pc); end
    start(); wait_idle(cyc);
    vectors++; if (cyc != 10 || dut.rf[4] !== 16'h9 || halted !== 1'b1) begin miscompares++; $display("FAIL pause_resume: got cyc=%0d r4=%h halted=%b want 10 0009 1", cyc, dut.rf[4], halted); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    clear_mem();
    put(0, 16'h8105); put(1, 16'h4804); put(2, 16'hC0F0); put(4, 16'hAAAA);
    do_reset(); start();
    cyc = 0;
    while (!m_we && cyc < 200) begin @(negedge clock); cyc++; end
    vectors++; if (m_we !== 1'b1 || phase !== 5'b01000) begin miscompares++; $display("FAIL rstmid_find: got we=%b phase=%b want 1 01000", m_we, phase); end
    reset = 1'b1; #1;
    vectors++; if (m_we !== 1'b0 || phase !== 5'b0 || running !== 1'b0) begin miscompares++; $display("FAIL rstmid_async: got we=%b phase=%b run=%b want 0 00000 0", m_we, phase, running); end
    vectors++; if (dut.pc !== '0 || dut.rf[1] !== '0) begin miscompares++; $display("FAIL rstmid_state: got pc=%h r1=%h want 000 0000", dut.pc, dut.rf[1]); end
    @(negedge clock); reset = 1'b0; @(negedge clock);
    vectors++; if (mem[4] !== 16'hAAAA) begin miscompares++; $display("FAIL rstmid_mem: got %h want aaaa", mem[4]); end
  endtask

  task automatic test_random();
    int cyc, n, a, k;
    logic [3:0] ops [0:10];
    ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10, 4'd11};
    for (int it = 0; it < 20; it++) begin
      clear_mem();
      for (int i = 0; i < 8; i++) put(16'h40 + i, 16'($urandom));
      a = 0;
      for (int i = 1; i <= 8; i++) begin
        put(a, {2'b00, 3'(i % 8), 3'b000, 8'(8'h40 + (i % 8))}); a++;
      end
      for (int j = 0; j < 12; j++) begin
        k = $urandom_range(0, 9);
        if (k == 0) put(a, {2'b10, 3'b000, 3'($urandom), 8'($urandom)});
        else if (k == 1) put(a, {2'b10, 3'b111, 1'b0, 2'($urandom), 8'h01});
        else put(a, {2'b11, 3'($urandom), 3'($urandom), ops[$urandom_range(0, 10)], 4'($urandom)});
        a++;
      end
      put(a, 16'hC0F0); put(a + 1, 16'hC0F0);
      model_run(n);
      do_reset(); start(); wait_idle(cyc);
      vectors++; if (cyc != 5 * n) begin miscompares++; $display("FAIL rand%0d_cycles: got %0d want %0d", it, cyc, 5 * n); end
      for (int i = 0; i < 8; i++) begin
        vectors++; if (dut.rf[i] !== exp_r[i]) begin miscompares++; $display("FAIL rand%0d_r%0d: got %h want %h", it, i, dut.rf[i], exp_r[i]); end
      end
      vectors++; if (dut.szcv !== exp_f) begin miscompares++; $display("FAIL rand%0d_szcv: got %b want %b", it, dut.szcv, exp_f); end
      vectors++; if (int'(dut.pc) != exp_pc) begin miscompares++; $display("FAIL rand%0d_pc: got %h want %h", it, dut.pc, exp_pc); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ld_st();
    test_branch();
    test_shift();
    test_pause();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
